// File: rtl/rf_wb_arbiter.sv
// Two-requester round-robin writeback arbiter driving a register-file write port,
// with a per-register pending-write scoreboard set at issue and cleared at writeback.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [AW-1:0]      req0_addr,
    input  logic [DW-1:0]      req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [AW-1:0]      req1_addr,
    input  logic [DW-1:0]      req1_data,
    output logic               req1_ready,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    output logic               WE3,
    output logic [AW-1:0]      A3,
    output logic [DW-1:0]      WD3,
    output logic [2**AW-1:0]   busy
);

    localparam int NREG = 2**AW;

    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_e;

    last_e           last_q;
    last_e           last_d;
    logic            sel;
    logic            xfer;
    logic [AW-1:0]   xaddr;
    logic [DW-1:0]   xdata;
    logic [NREG-1:0] busy_d;

    // Last-grant pointer starts at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= LAST_REQ1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = sel ? LAST_REQ1 : LAST_REQ0;
        end
    end

    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = (last_q == LAST_REQ0);
        end else begin
            sel = req1_valid;
        end
        req0_ready = rst & req0_valid & ~sel;
        req1_ready = rst & req1_valid & sel;
        xfer       = req0_ready | req1_ready;
        xaddr      = sel ? req1_addr : req0_addr;
        xdata      = sel ? req1_data : req0_data;
    end

    // Reserve is applied after the clear so a same-address reserve keeps the bit set.
    always_comb begin
        busy_d = busy;
        if (xfer) begin
            busy_d[xaddr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE3 <= xfer && (xaddr != '0);
            if (xfer) begin
                A3  <= xaddr;
                WD3 <= xdata;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter: arbitration, write port timing,
// scoreboard set/clear rules and asynchronous reset behaviour.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] busy;

    int tests;
    int fails;

    rf_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsv_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        idle_inputs();
        req0_addr  = 5'd0;
        req0_data  = 32'h0;
        req1_addr  = 5'd0;
        req1_data  = 32'h0;
        rsv_addr   = 5'd0;
        #2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        tests++; if (WE3 !== 1'b0) begin fails++; $display("FAIL reset_we3 got %0b exp 0", WE3); end
        tests++; if (A3 !== 5'd0) begin fails++; $display("FAIL reset_a3 got %0d exp 0", A3); end
        tests++; if (WD3 !== 32'h0) begin fails++; $display("FAIL reset_wd3 got %h exp 0", WD3); end
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL reset_busy got %h exp 0", busy); end
        tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0 got %0b exp 0", req0_ready); end
        tests++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready1 got %0b exp 0", req1_ready); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'hDEADBEEF;
        #1;
        tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL single_ready0 got %0b exp 1", req0_ready); end
        tests++; if (req1_ready !== 1'b0) begin fails++; $display("FAIL single_ready1 got %0b exp 0", req1_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        tests++; if (WE3 !== 1'b1) begin fails++; $display("FAIL single_we3 got %0b exp 1", WE3); end
        tests++; if (A3 !== 5'd5) begin fails++; $display("FAIL single_a3 got %0d exp 5", A3); end
        tests++; if (WD3 !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wd3 got %h exp deadbeef", WD3); end
        @(posedge clk); #1;
        tests++; if (WE3 !== 1'b0) begin fails++; $display("FAIL single_we3_drop got %0b exp 0", WE3); end
        tests++; if (A3 !== 5'd5) begin fails++; $display("FAIL single_a3_hold got %0d exp 5", A3); end
        tests++; if (WD3 !== 32'hDEADBEEF) begin fails++; $display("FAIL single_wd3_hold got %h exp deadbeef", WD3); end
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 5'd3;
        req0_data  = 32'h0000_0333;
        req1_valid = 1'b1;
        req1_addr  = 5'd7;
        req1_data  = 32'h0000_0777;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (req0_ready !== (i % 2 == 0)) begin fails++; $display("FAIL rr_ready0[%0d] got %0b exp %0b", i, req0_ready, (i % 2 == 0)); end
            tests++; if (req1_ready !== (i % 2 == 1)) begin fails++; $display("FAIL rr_ready1[%0d] got %0b exp %0b", i, req1_ready, (i % 2 == 1)); end
            exp_addr = (i % 2 == 0) ? 5'd3 : 5'd7;
            exp_data = (i % 2 == 0) ? 32'h0000_0333 : 32'h0000_0777;
            @(posedge clk); #1;
            tests++; if (WE3 !== 1'b1) begin fails++; $display("FAIL rr_we3[%0d] got %0b exp 1", i, WE3); end
            tests++; if (A3 !== exp_addr) begin fails++; $display("FAIL rr_a3[%0d] got %0d exp %0d", i, A3, exp_addr); end
            tests++; if (WD3 !== exp_data) begin fails++; $display("FAIL rr_wd3[%0d] got %h exp %h", i, WD3, exp_data); end
        end
        idle_inputs();
        @(posedge clk); #1;
        tests++; if (WE3 !== 1'b0) begin fails++; $display("FAIL rr_we3_idle got %0b exp 0", WE3); end
    endtask

    task automatic test_reserve_clear();
        @(negedge clk);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        @(posedge clk); #1;
        rsv_valid = 1'b0;
        tests++; if (busy !== 32'h0000_0200) begin fails++; $display("FAIL rsv9_set got %h exp 00000200", busy); end
        @(posedge clk); #1;
        tests++; if (busy !== 32'h0000_0200) begin fails++; $display("FAIL rsv9_hold got %h exp 00000200", busy); end
        req1_valid = 1'b1;
        req1_addr  = 5'd9;
        req1_data  = 32'h0000_0099;
        #1;
        tests++; if (req1_ready !== 1'b1) begin fails++; $display("FAIL rsv9_ready1 got %0b exp 1", req1_ready); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL rsv9_clear got %h exp 0", busy); end
        tests++; if (WE3 !== 1'b1 || A3 !== 5'd9) begin fails++; $display("FAIL rsv9_write got we3=%0b a3=%0d exp we3=1 a3=9", WE3, A3); end
    endtask

    task automatic test_reserve_wins();
        @(negedge clk);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd12;
        @(posedge clk); #1;
        tests++; if (busy !== 32'h0000_1000) begin fails++; $display("FAIL rsv12_pre got %h exp 00001000", busy); end
        req0_valid = 1'b1;
        req0_addr  = 5'd12;
        req0_data  = 32'h0000_000C;
        @(posedge clk); #1;
        tests++; if (busy !== 32'h0000_1000) begin fails++; $display("FAIL rsv12_wins got %h exp 00001000", busy); end
        tests++; if (WE3 !== 1'b1 || A3 !== 5'd12) begin fails++; $display("FAIL rsv12_write got we3=%0b a3=%0d exp we3=1 a3=12", WE3, A3); end
        rsv_addr = 5'd4;
        @(posedge clk); #1;
        idle_inputs();
        tests++; if (busy !== 32'h0000_0010) begin fails++; $display("FAIL rsv4_xfer12 got %h exp 00000010", busy); end
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr  = 5'd0;
        req0_data  = 32'h1;
        rsv_valid  = 1'b1;
        rsv_addr   = 5'd0;
        #1;
        tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL zero_ready0 got %0b exp 1", req0_ready); end
        @(posedge clk); #1;
        idle_inputs();
        tests++; if (WE3 !== 1'b0) begin fails++; $display("FAIL zero_we3 got %0b exp 0", WE3); end
        tests++; if (busy !== 32'h0000_0010) begin fails++; $display("FAIL zero_busy got %h exp 00000010", busy); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_addr  = 5'd4;
        req0_data  = 32'h0000_0044;
        rsv_valid  = 1'b1;
        rsv_addr   = 5'd9;
        @(posedge clk); #1;
        idle_inputs();
        tests++; if (WE3 !== 1'b1) begin fails++; $display("FAIL arst_pre_we3 got %0b exp 1", WE3); end
        tests++; if (busy !== 32'h0000_0200) begin fails++; $display("FAIL arst_pre_busy got %h exp 00000200", busy); end
        #1;
        rst = 1'b0;
        #1;
        tests++; if (WE3 !== 1'b0) begin fails++; $display("FAIL arst_we3 got %0b exp 0", WE3); end
        tests++; if (busy !== 32'h0) begin fails++; $display("FAIL arst_busy got %h exp 0", busy); end
        tests++; if (A3 !== 5'd0 || WD3 !== 32'h0) begin fails++; $display("FAIL arst_port got a3=%0d wd3=%h exp 0", A3, WD3); end
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 5'd2;
        req0_data  = 32'h0000_0022;
        req1_valid = 1'b1;
        req1_addr  = 5'd6;
        req1_data  = 32'h0000_0066;
        #1;
        tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL arst_first_grant got r0=%0b r1=%0b exp r0=1 r1=0", req0_ready, req1_ready); end
        @(posedge clk); #1;
        idle_inputs();
        tests++; if (WE3 !== 1'b1 || A3 !== 5'd2) begin fails++; $display("FAIL arst_first_write got we3=%0b a3=%0d exp we3=1 a3=2", WE3, A3); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_reserve_clear();
        test_reserve_wins();
        test_addr_zero();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, as the write-data width.
REQ-002 The block SHALL have parameter AW, default 5, as the register-address width; the register count is 2**AW.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: a writeback request is present from requester 0 or 1.
REQ-006 The block SHALL have ports req0_addr and req1_addr, input, AW bits each: destination register.
REQ-007 The block SHALL have ports req0_data and req1_data, input, DW bits each: writeback data.
REQ-008 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the request is accepted this cycle.
REQ-009 The block SHALL have port rsv_valid, input, 1 bit, and port rsv_addr, input, AW bits: mark a destination register pending at issue.
REQ-010 The block SHALL have ports WE3 (output, 1 bit), A3 (output, AW bits) and WD3 (output, DW bits): the register-file write port.
REQ-011 The block SHALL have port busy, output, 2**AW bits: per-register pending-write scoreboard.

Function
REQ-012 A transfer SHALL occur on reqN when reqN_valid=1 and reqN_ready=1 at the same rising clk edge.
REQ-013 reqN_ready SHALL be combinational, and SHALL be 1 only when reqN_valid=1 and requester N holds the grant.
REQ-014 At most one of req0_ready and req1_ready SHALL be 1 in any cycle.
REQ-015 A single valid requester SHALL be granted in the same cycle.
REQ-016 When both requesters are valid, the grant SHALL go to the requester not granted at the most recent transfer (round-robin); the last-grant pointer SHALL update only on a transfer.
REQ-017 A transfer SHALL register WE3=1, A3=addr and WD3=data at that edge, so the write is visible one cycle after acceptance.
REQ-018 Without a transfer, WE3 SHALL be 0 in the next cycle, and A3/WD3 SHALL hold their previous values.
REQ-019 A transfer to address 0 SHALL be accepted (ready=1), but SHALL produce WE3=0.
REQ-020 Requesters SHALL hold valid, addr and data stable until accepted; the arbiter is not required to tolerate withdrawal.
REQ-021 busy[rsv_addr] SHALL be set at the clock edge where rsv_valid=1, except that address 0 SHALL never be set.
REQ-022 busy[addr] SHALL be cleared at the clock edge of a transfer to addr.
REQ-023 When a reserve and a transfer target the same address at the same edge, the reserve SHALL win and busy SHALL remain 1.
REQ-024 Reserves and transfers to different addresses at the same edge SHALL both take effect.
REQ-025 A transfer to a non-busy address SHALL be accepted normally and SHALL leave busy unchanged.
REQ-026 busy[0] SHALL be 0 at all times.

Reset
REQ-027 While rst=0, WE3, A3, WD3 and busy SHALL be 0 and the last-grant pointer SHALL be 1, so requester 0 wins the first contention; this SHALL take effect immediately, without a clock edge.
REQ-028 While rst=0, req0_ready and req1_ready SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard any registered, not-yet-written request and clear all busy bits.
REQ-030 After rst rises, the first clk edge SHALL behave as a normal cycle.

Verification
REQ-031 Bench SHALL cover: req0 only, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF; the cycle after, WE3=0.
REQ-032 Bench SHALL cover: both requesters valid for 4 cycles after reset, with addresses 3 and 7 -> grants in the order 0,1,0,1, and WE3 pulses A3=3,7,3,7 each one cycle later.
REQ-033 Bench SHALL cover: reserve addr 9, then transfer to 9 two cycles later -> busy[9]=1 after the reserve edge and 0 after the transfer edge.
REQ-034 Bench SHALL cover: reserve 12 and transfer 12 at the same edge with busy[12]=1 beforehand -> busy[12] remains 1 and WE3=1, A3=12 the next cycle.
REQ-035 Bench SHALL cover: transfer to addr 0 with data 0x1 -> ready=1, WE3 remains 0; and reserve of 0 -> busy[0] remains 0.
REQ-036 Bench SHALL cover: rst driven low between clock edges while WE3=1 and busy=0x00000200 -> WE3=0 and busy=0 immediately, with no clk edge required.
